pwm_to_pcm: RTL
===============

// Module: pwm_to_pcm
// PURPOSE
//  Receive-side counterpart of the PCM-to-PWM encoder: measures the duty cycle of a
//  fixed-period PWM stream and recovers one signed 16-bit PCM sample per PWM frame.
//  Sits between an external/loopback PWM pin and a PCM consumer (FIFO, codec checker).
//  The sample is offered on a valid/ack handshake identical to the encoder's PCM input side.
// PARAMETERS
//  PERIOD_BITS  8  frame length = 2**PERIOD_BITS clk cycles; legal range 1..16
// PORTS
//  clk          input   1   system clock, all logic on posedge
//  rst          input   1   synchronous, active-high reset
//  PWM          input   1   PWM stream, asynchronous to clk
//  PCM_data     output  16  recovered sample, signed two's complement
//  PCM_valid    output  1   PCM_data holds an un-acknowledged sample
//  PCM_ack      input   1   consumer accepts the sample on a clk edge where PCM_valid=1
//  PCM_overrun  output  1   sticky: a sample was overwritten before ack; cleared by rst only
// BEHAVIOUR
//  - Reset (rst=1 at posedge): PCM_data=16'h0000, PCM_valid=0, PCM_overrun=0,
//    state=ALIGN, frame_cnt=0, high_cnt=0, sync flops=0. Reset mid-frame discards partial count.
//  - Input: PWM passes a 2-flop synchronizer -> pwm_s; pwm_d = pwm_s delayed 1 cycle;
//    rise = pwm_s & ~pwm_d. Pin-to-pwm_s latency 2 cycles.
//  - FSM ALIGN: wait for rise. On rise: frame_cnt<=1, high_cnt<=1, go MEASURE.
//  - FSM MEASURE: every cycle frame_cnt++ (PERIOD_BITS wide), high_cnt += pwm_s
//    (PERIOD_BITS+1 wide). On cycle with frame_cnt==2**PERIOD_BITS-1:
//    d = high_cnt + pwm_s (0..2**PERIOD_BITS); register PCM_data<=conv(d), PCM_valid<=1,
//    frame_cnt<=0, high_cnt<=0; stay MEASURE (frames back-to-back, no realignment).
//  - conv(d): s = d - 2**(PERIOD_BITS-1); PCM_data = s <<< (16-PERIOD_BITS);
//    if d==2**PERIOD_BITS then PCM_data=16'h7FFF (saturate). All arithmetic signed, 17-bit internal.
//  - Sample visible on PCM_data/PCM_valid the cycle after the frame's last cycle.
//  - Handshake: PCM_data stable while PCM_valid=1 and no new frame completes.
//    PCM_ack=1 & PCM_valid=1 at posedge -> PCM_valid<=0. PCM_ack while PCM_valid=0 ignored.
//  - Simultaneous frame-complete and ack: new sample loaded, PCM_valid stays 1, no overrun.
//  - Frame-complete while PCM_valid=1 and no ack: new sample overwrites, PCM_overrun<=1.
//  - PWM stuck low/high after alignment: frames keep completing (d=0 -> 16'h8000,
//    d=full -> 16'h7FFF). PWM never rising: stays in ALIGN, PCM_valid never asserts.
// STRUCTURE
//  - pcm_pkg: PCM_WIDTH=16, typedef logic signed [PCM_WIDTH-1:0] pcm_sample_t,
//    typedef enum logic {ALIGN, MEASURE} pwm_rx_state_t, PCM_MAX=16'h7FFF, PCM_MIN=16'h8000.
//  - Sub-module pwm_input_sync: 2-flop synchronizer + rise detect (outputs pwm_s, rise).
//  - Top holds FSM, counters, converter, output/handshake registers.
// TESTING  (PERIOD_BITS=4, 16-cycle frames, PWM driven on clk edges)
//  - Encoder-style waveform high 8 of 16 cycles, rising at frame start, ack each sample
//    -> every PCM_data=16'h0000, one PCM_valid per 16 cycles after first frame.
//  - High 4 of 16 -> 16'hC000; high 15 of 16 -> 16'h7000; high 1 of 16 -> 16'h9000.
//  - One rise then PWM held high -> 16'h7FFF repeated; held low after rise -> 16'h8000 repeated.
//  - Never ack across two frames -> second sample replaces first, PCM_overrun=1 and stays 1;
//    ack on exact frame-complete edge -> PCM_valid stays 1, PCM_overrun stays 0.
//  - rst pulsed mid-frame -> next cycle all outputs zero, state ALIGN; no sample until new
//    rise plus full frame; PWM held low from reset -> PCM_valid never asserts.
//  - Loopback: PCM-to-PWM encoder driving PWM with a random sample sequence -> recovered
//    samples equal encoder inputs truncated to top PERIOD_BITS bits (scoreboard compare).

Source files
------------

// File: rtl/pcm_pkg.sv
// Shared PCM types, limits and the duty-to-sample conversion used by the PWM receiver.
package pcm_pkg;

    localparam int unsigned PCM_WIDTH = 16;
    localparam int unsigned CONV_W    = PCM_WIDTH + 1;

    typedef logic signed [PCM_WIDTH-1:0] pcm_sample_t;

    typedef enum logic {
        ALIGN   = 1'b0,
        MEASURE = 1'b1
    } pwm_rx_state_t;

    localparam pcm_sample_t PCM_MAX = 16'h7FFF;
    localparam pcm_sample_t PCM_MIN = 16'h8000;

    // Map a high-cycle count (0..2**period_bits) onto the full signed PCM range.
    // Mid-scale duty maps to zero; a completely high frame saturates to PCM_MAX.
    function automatic pcm_sample_t pcm_from_duty(
        input logic [CONV_W-1:0] duty,
        input int unsigned       period_bits
    );
        logic        [CONV_W-1:0] full;
        logic        [CONV_W-1:0] half;
        logic signed [CONV_W-1:0] centred;
        logic signed [CONV_W-1:0] scaled;
        full    = CONV_W'(1) << period_bits;
        half    = full >> 1;
        centred = $signed(duty - half);
        scaled  = centred <<< (PCM_WIDTH - period_bits);
        if (duty == full) begin
            return PCM_MAX;
        end
        return scaled[PCM_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/pwm_input_sync.sv
// Two-flop synchronizer for the asynchronous PWM pin plus a rising-edge detector.
module pwm_input_sync (
    input  logic clk,
    input  logic rst,
    input  logic pwm_i,
    output logic pwm_s_o,
    output logic rise_c_o
);

    logic meta_q;
    logic sync_q;
    logic dly_q;

    // Synchronizer chain and one-cycle delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            dly_q  <= 1'b0;
        end else begin
            meta_q <= pwm_i;
            sync_q <= meta_q;
            dly_q  <= sync_q;
        end
    end

    assign pwm_s_o  = sync_q;
    assign rise_c_o = sync_q & ~dly_q;

endmodule

// File: rtl/pwm_to_pcm.sv
// Recovers one signed PCM sample per fixed-length PWM frame by counting high cycles.
module pwm_to_pcm
    import pcm_pkg::*;
#(
    parameter int unsigned PERIOD_BITS = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        PWM,
    output logic signed [PCM_WIDTH-1:0] PCM_data,
    output logic                        PCM_valid,
    input  logic                        PCM_ack,
    output logic                        PCM_overrun
);

    localparam int unsigned FRAME_W = PERIOD_BITS;
    localparam int unsigned HIGH_W  = PERIOD_BITS + 1;
    localparam logic [FRAME_W-1:0] FRAME_LAST = '1;

    logic pwm_s;
    logic rise_c;

    pwm_rx_state_t        state_q,   state_d;
    logic [FRAME_W-1:0]   frame_q,   frame_d;
    logic [HIGH_W-1:0]    high_q,    high_d;
    pcm_sample_t          data_q,    data_d;
    logic                 valid_q,   valid_d;
    logic                 overrun_q, overrun_d;
    logic [HIGH_W-1:0]    duty_c;

    pwm_input_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .pwm_i    (PWM),
        .pwm_s_o  (pwm_s),
        .rise_c_o (rise_c)
    );

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ALIGN;
            frame_q   <= '0;
            high_q    <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            high_q    <= high_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    // Alignment/measurement FSM, sample conversion and valid/ack handshake.
    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        high_d    = high_q;
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        duty_c    = high_q + HIGH_W'(pwm_s);

        if (valid_q && PCM_ack) begin
            valid_d = 1'b0;
        end

        case (state_q)
            ALIGN: begin
                // The rising-edge cycle is the first, high, cycle of the frame.
                if (rise_c) begin
                    frame_d = FRAME_W'(1);
                    high_d  = HIGH_W'(1);
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                frame_d = frame_q + FRAME_W'(1);
                high_d  = duty_c;
                if (frame_q == FRAME_LAST) begin
                    frame_d = '0;
                    high_d  = '0;
                    data_d  = pcm_from_duty(CONV_W'(duty_c), PERIOD_BITS);
                    valid_d = 1'b1;
                    // A simultaneous ack consumes the old sample, so only an
                    // unacknowledged one counts as lost.
                    if (valid_q && !PCM_ack) begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ALIGN;
            end
        endcase
    end

    assign PCM_data    = data_q;
    assign PCM_valid   = valid_q;
    assign PCM_overrun = overrun_q;

endmodule
